// File: rtl/aucohl_uart_rx.sv
// aucohl_uart_rx: oversampling (16x) UART receiver feeding an aucohl_fifo write port.
// Latency: the wr/error pulse is registered, one clock after the stop-bit sample tick.
// Backpressure: none toward the line; fifo_full at stop sample drops the byte (overrun_err).
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   en                    receiver enable (low forces IDLE, discards the frame)
//   rx                    asynchronous serial input, idle high
//   clk_div [PW-1:0]      clocks per 1/16-bit sample tick (0 behaves as 1)
//   parity_en/parity_odd  parity bit present / odd(1) or even(0) parity
//   fifo_full             downstream FIFO full flag
//   wr, wdata             FIFO write strobe and data (wdata held between writes)
//   frame_err, parity_err, overrun_err   single-cycle outcome pulses
//   busy                  high whenever the FSM is not IDLE
module aucohl_uart_rx #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rx,
  input  logic [PW-1:0] clk_div,
  input  logic          parity_en,
  input  logic          parity_odd,
  input  logic          fifo_full,
  output logic          wr,
  output logic [7:0]    wdata,
  output logic          frame_err,
  output logic          parity_err,
  output logic          overrun_err,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic          rx_meta, rx_s;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] div_m1;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          tick;

  // Strobes from the output process
  logic start_go, start_smp, bit_smp, par_smp, stop_smp;
  logic do_wr, do_frame, do_par, do_ovr;

  // Reload value; clk_div of 0 is treated as 1 (reload 0, tick every clock)
  assign div_m1 = (clk_div == '0) ? '0 : clk_div - 1'b1;

  // Prescaler only runs outside IDLE; tick on terminal count
  assign tick = (state != S_IDLE) && (pre_cnt == '0);

  // Two-flop synchroniser, idle-high reset so no false start after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (!rx_s) state_nxt = S_START;
        S_START:  if (tick && samp_cnt == 4'd7)
                    state_nxt = rx_s ? S_IDLE : S_DATA;
        S_DATA:   if (tick && samp_cnt == 4'd15 && bit_cnt == 3'd7)
                    state_nxt = parity_en ? S_PARITY : S_STOP;
        S_PARITY: if (tick && samp_cnt == 4'd15) state_nxt = S_STOP;
        S_STOP:   if (tick && samp_cnt == 4'd15) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs and sample strobes (all gated by en so an abort emits nothing)
  always_comb begin
    busy      = (state != S_IDLE);
    start_go  = en && (state == S_IDLE) && !rx_s;
    start_smp = en && (state == S_START)  && tick && (samp_cnt == 4'd7);
    bit_smp   = en && (state == S_DATA)   && tick && (samp_cnt == 4'd15);
    par_smp   = en && (state == S_PARITY) && tick && (samp_cnt == 4'd15);
    stop_smp  = en && (state == S_STOP)   && tick && (samp_cnt == 4'd15);
    // Exactly one outcome per frame: frame > parity > overrun > write
    do_frame  = stop_smp && !rx_s;
    do_par    = stop_smp && rx_s && par_bad;
    do_ovr    = stop_smp && rx_s && !par_bad && fifo_full;
    do_wr     = stop_smp && rx_s && !par_bad && !fifo_full;
  end

  // Prescaler and sample counter. Loading div_m1 at start detection places
  // tick k exactly k*D clocks after the detection clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      samp_cnt <= '0;
    end else if (start_go) begin
      pre_cnt  <= div_m1;
      samp_cnt <= '0;
    end else if (state != S_IDLE) begin
      pre_cnt <= tick ? div_m1 : pre_cnt - 1'b1;
      if (start_smp)  samp_cnt <= '0;  // realign so data bits sample at samp_cnt 15
      else if (tick)  samp_cnt <= samp_cnt + 1'b1;
    end
  end

  // Data shift register (LSB first), bit counter, parity check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_go) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (bit_smp) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_smp) par_bad <= (^shreg) ^ rx_s ^ parity_odd;
    end
  end

  // Registered outcome pulses; wdata only updates on a successful write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr          <= 1'b0;
      wdata       <= 8'h00;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      wr          <= do_wr;
      frame_err   <= do_frame;
      parity_err  <= do_par;
      overrun_err <= do_ovr;
      if (do_wr) wdata <= shreg;
    end
  end

endmodule

// File: tb/tb_aucohl_uart_rx.sv
// tb_aucohl_uart_rx: directed + randomized frames against a frame-level model.
// Latency: expected pulse cycle = detection clock + sample tick * D + 1.
// Backpressure: fifo_full driven during the stop bit to provoke overruns.
module tb_aucohl_uart_rx;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          rx = 1'b1;
  logic [PW-1:0] clk_div = 16'd4;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          fifo_full = 1'b0;
  logic          wr;
  logic [7:0]    wdata;
  logic          frame_err, parity_err, overrun_err, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Observed pulse event: cycle, {ovr,par,frm,wr}, wdata, busy in that clock
  typedef struct {
    int         c;
    logic [3:0] k;
    logic [7:0] d;
    logic       b;
  } ev_t;
  ev_t ev_q[$];

  logic [7:0] last_good = 8'h00;

  aucohl_uart_rx #(.PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx), .clk_div(clk_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .fifo_full(fifo_full),
    .wr(wr), .wdata(wdata), .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (wr || frame_err || parity_err || overrun_err) begin
      e.c = cyc;
      e.k = {overrun_err, parity_err, frame_err, wr};
      e.d = wdata;
      e.b = busy;
      ev_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int deff();
    return (clk_div == '0) ? 1 : int'(clk_div);
  endfunction

  // Drive one frame on rx, one bit per 16*D clocks; n0 = cycle rx fell
  task automatic send_frame(input logic [7:0] b, input bit pe, input bit po, input bit pflip,
                            input bit stop_v, input bit full, output int n0);
    int bt;
    bt = 16 * deff();
    @(negedge clk);
    n0 = cyc;
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bt) @(negedge clk);
    end
    if (pe) begin
      rx = (^b) ^ po ^ pflip;
      repeat (bt) @(negedge clk);
    end
    rx = stop_v;
    fifo_full = full;
    repeat (bt) @(negedge clk);
    rx = 1'b1;
    fifo_full = 1'b0;
  endtask

  task automatic expect_none(input string tag);
    chk({tag, " no_pulse"}, ev_q.size(), 0);
    ev_q.delete();
  endtask

  task automatic expect_one(input string tag, input logic [3:0] k, input int c, input logic [7:0] d);
    chk({tag, " count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk({tag, " kind"}, ev_q[0].k, k);
      chk({tag, " cycle"}, ev_q[0].c, c);
      chk({tag, " wdata"}, ev_q[0].d, d);
      chk({tag, " busy_low"}, ev_q[0].b, 1'b0);
    end
    ev_q.delete();
  endtask

  // Whole-frame model: outcome from priority rules, timing from sample-tick table
  task automatic run_frame(input string tag, input logic [7:0] b, input bit pe, input bit po,
                           input bit pflip, input bit stop_v, input bit full);
    int n0, d, stop_tick;
    logic [3:0] k;
    d = deff();
    parity_en = pe;
    parity_odd = po;
    send_frame(b, pe, po, pflip, stop_v, full, n0);
    repeat (20 * d) @(negedge clk);
    if (!stop_v)          k = 4'b0010;
    else if (pe && pflip) k = 4'b0100;
    else if (full)        k = 4'b1000;
    else begin
      k = 4'b0001;
      last_good = b;
    end
    stop_tick = pe ? 168 : 152;
    expect_one(tag, k, n0 + 2 + stop_tick * d + 1, last_good);
  endtask

  initial begin
    int n0, d;
    repeat (3) @(negedge clk);
    chk("reset outs", {wr, wdata, frame_err, parity_err, overrun_err, busy}, 13'h0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);

    clk_div = 16'd4;
    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("03_even_ok", 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("03_even_bad", 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // False start: 6-tick low pulse, busy must drop right after tick 8
    parity_en = 1'b0;
    d = deff();
    @(negedge clk);
    n0 = cyc;
    rx = 1'b0;
    repeat (6 * d) @(negedge clk);
    chk("false_start busy_hi", busy, 1'b1);
    rx = 1'b1;
    repeat (2 + 2 * d) @(negedge clk);
    chk("false_start busy_tick8", busy, 1'b1);
    @(negedge clk);
    chk("false_start busy_fall", busy, 1'b0);
    repeat (20 * d) @(negedge clk);
    expect_none("false_start");
    run_frame("5a_after_false", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    run_frame("ff_frame_err", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("42_overrun", 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame("after_overrun", 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Enable dropped at data bit 4; frame discarded silently
    fork
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n0);
      begin
        repeat (16 * d * 5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop busy", busy, 1'b0);
      end
    join
    repeat (20 * d) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    expect_none("en_drop");
    run_frame("11_after_en", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame: held until the line is idle again
    fork
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n0);
      begin
        repeat (16 * d * 4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset outs", {wr, wdata, frame_err, parity_err, overrun_err, busy}, 13'h0);
      end
    join
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * d) @(negedge clk);
    expect_none("midreset");
    run_frame("after_reset", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames across prescaler values, parity modes and errors
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit pe, po, pf, sv, fl;
      clk_div = 16'($urandom_range(0, 4));
      b  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      pf = pe && ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 5) != 0);
      fl = ($urandom_range(0, 3) == 0);
      run_frame("rand", b, pe, po, pf, sv, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
